// File: rtl/ysyx_23060187_pkg.sv
// Shared decode definitions: opcode map, immediate-format codes and the
// layout of the per-entry decoded field bundle.
package ysyx_23060187_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_32       = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    ITYPE_R    = 3'd0,
    ITYPE_I    = 3'd1,
    ITYPE_S    = 3'd2,
    ITYPE_B    = 3'd3,
    ITYPE_U    = 3'd4,
    ITYPE_J    = 3'd5,
    ITYPE_NONE = 3'd7
  } itype_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] fun3;
    logic [6:0] fun7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_wen;
    itype_e     itype;
    logic       illegal;
  } dec_fields_t;

  localparam int DEC_FIELDS_W = 37;

  // A held entry is {pc, imm, fields}.
  function automatic int dec_bundle_w(input int xlen);
    return 2 * xlen + DEC_FIELDS_W;
  endfunction

endpackage

// File: rtl/ysyx_23060187_decode_stage_if.sv
// IFU->decode and decode->EXU handshake plus the decoded bundle.
interface ysyx_23060187_decode_stage_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_inst;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [2:0]      out_fun3;
  logic [6:0]      out_fun7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rd_wen;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_itype;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_fun3, out_fun7,
           out_rs1, out_rs2, out_rd, out_rd_wen, out_imm, out_itype, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_fun3, out_fun7,
           out_rs1, out_rs2, out_rd, out_rd_wen, out_imm, out_itype, out_illegal
  );

endinterface

// File: rtl/ysyx_23060187_imm_gen.sv
// Combinational opcode classifier and sign-extended immediate builder.
module ysyx_23060187_imm_gen
  import ysyx_23060187_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_RV64   = 1'b0,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output itype_e          itype,
  output logic            illegal
);

  // Any opcode not matched (including inst[1:0] != 2'b11) falls to NONE.
  always_comb begin
    itype = ITYPE_NONE;
    case (inst[6:0])
      OP_LUI, OP_AUIPC:          itype = ITYPE_U;
      OP_LOAD, OP_IMM, OP_JALR:  itype = ITYPE_I;
      OP_JAL:                    itype = ITYPE_J;
      OP_BRANCH:                 itype = ITYPE_B;
      OP_STORE:                  itype = ITYPE_S;
      OP_OP:                     itype = ITYPE_R;
      OP_IMM_32:                 if (EN_RV64) itype = ITYPE_I;
      OP_32:                     if (EN_RV64) itype = ITYPE_R;
      OP_SYSTEM, OP_MISC_MEM:    if (EN_SYSTEM) itype = ITYPE_I;
      default:                   itype = ITYPE_NONE;
    endcase
  end

  assign illegal = (itype == ITYPE_NONE);

  // Size casts of signed operands replicate inst[31] up to XLEN.
  always_comb begin
    imm = '0;
    case (itype)
      ITYPE_I: imm = XLEN'($signed(inst[31:20]));
      ITYPE_S: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      ITYPE_B: imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      ITYPE_U: imm = XLEN'($signed({inst[31:12], 12'b0}));
      ITYPE_J: imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060187_decode_stage.sv
// Decode stage: decodes on acceptance, holds results in a main register backed
// by one skid entry so in_ready is registered yet throughput stays at one/cycle.
module ysyx_23060187_decode_stage
  import ysyx_23060187_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_RV64   = 1'b0,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  ysyx_23060187_decode_stage_if.slave io
);

  localparam int BW = dec_bundle_w(XLEN);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_MAIN  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [BW-1:0]   main_q, skid_q, dec_bundle;
  logic            in_ready_q;
  logic            accept;
  logic            load_main, load_skid, promote;
  logic [XLEN-1:0] dec_imm;
  itype_e          dec_itype;
  logic            dec_illegal;
  dec_fields_t     dec_f, out_f;

  ysyx_23060187_imm_gen #(
    .XLEN      (XLEN),
    .EN_RV64   (EN_RV64),
    .EN_SYSTEM (EN_SYSTEM)
  ) u_imm_gen (
    .inst    (io.in_inst),
    .imm     (dec_imm),
    .itype   (dec_itype),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec_f         = '0;
    dec_f.opcode  = io.in_inst[6:0];
    dec_f.fun3    = io.in_inst[14:12];
    dec_f.fun7    = io.in_inst[31:25];
    dec_f.rs1     = io.in_inst[19:15];
    dec_f.rs2     = io.in_inst[24:20];
    dec_f.rd      = io.in_inst[11:7];
    dec_f.rd_wen  = (dec_itype inside {ITYPE_R, ITYPE_I, ITYPE_U, ITYPE_J}) &&
                    (io.in_inst[11:7] != 5'd0);
    dec_f.itype   = dec_itype;
    dec_f.illegal = dec_illegal;
  end

  assign dec_bundle = {io.in_pc, dec_imm, dec_f};
  assign accept     = io.in_valid && in_ready_q;

  // Occupancy FSM; flush overrides every transition and every load.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    promote   = 1'b0;
    case (state_q)
      ST_EMPTY: if (accept) begin
        state_d   = ST_MAIN;
        load_main = 1'b1;
      end
      ST_MAIN: begin
        if (accept && io.out_ready) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = ST_SKID;
          load_skid = 1'b1;
        end else if (io.out_ready) begin
          state_d   = ST_EMPTY;
        end
      end
      ST_SKID: if (io.out_ready) begin
        state_d = ST_MAIN;
        promote = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d   = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      promote   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_SKID);
      if (load_main)    main_q <= dec_bundle;
      else if (promote) main_q <= skid_q;
      if (load_skid)    skid_q <= dec_bundle;
    end
  end

  assign out_f          = dec_fields_t'(main_q[DEC_FIELDS_W-1:0]);
  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = (state_q != ST_EMPTY);
  assign io.out_pc      = main_q[DEC_FIELDS_W+XLEN +: XLEN];
  assign io.out_imm     = main_q[DEC_FIELDS_W +: XLEN];
  assign io.out_opcode  = out_f.opcode;
  assign io.out_fun3    = out_f.fun3;
  assign io.out_fun7    = out_f.fun7;
  assign io.out_rs1     = out_f.rs1;
  assign io.out_rs2     = out_f.rs2;
  assign io.out_rd      = out_f.rd;
  assign io.out_rd_wen  = out_f.rd_wen;
  assign io.out_itype   = out_f.itype;
  assign io.out_illegal = out_f.illegal;

endmodule

// File: tb/tb_ysyx_23060187_decode_stage.sv
// Bench for the decode stage: an RV32 instance and an RV64 instance run in
// lockstep against a queue-based occupancy model and a reference decoder.
module tb_ysyx_23060187_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [2:0]  itype;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic in_ready;
    logic out_valid;
    exp_t e;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  obs_t obs0, obs1;

  always #5 clk = ~clk;

  ysyx_23060187_decode_stage_if #(.XLEN(32)) bus32 ();
  ysyx_23060187_decode_stage_if #(.XLEN(64)) bus64 ();

  ysyx_23060187_decode_stage #(.XLEN(32), .EN_RV64(1'b0), .EN_SYSTEM(1'b1)) dut32 (
    .clk (clk), .rst (rst), .flush (flush), .io (bus32)
  );

  ysyx_23060187_decode_stage #(.XLEN(64), .EN_RV64(1'b1), .EN_SYSTEM(1'b0)) dut64 (
    .clk (clk), .rst (rst), .flush (flush), .io (bus64)
  );

  function automatic longint sext(input longint val, input int bits);
    if (val >= (longint'(1) << (bits - 1))) return val - (longint'(1) << bits);
    return val;
  endfunction

  // Reference decoder: format chosen from the opcode table, immediate computed as a signed number.
  function automatic exp_t refDecode(input logic [63:0] pc, input logic [31:0] inst,
                                     input int xlen, input bit rv64, input bit sys);
    exp_t   e;
    longint v;
    int     fmt;
    e = '0;
    e.pc = pc;
    e.opcode = inst[6:0];
    e.fun3 = inst[14:12];
    e.fun7 = inst[31:25];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd = inst[11:7];
    case (inst[6:0])
      7'h37, 7'h17:        fmt = 4;
      7'h03, 7'h13, 7'h67: fmt = 1;
      7'h6F:               fmt = 5;
      7'h63:               fmt = 3;
      7'h23:               fmt = 2;
      7'h33:               fmt = 0;
      7'h1B:               fmt = rv64 ? 1 : 7;
      7'h3B:               fmt = rv64 ? 0 : 7;
      7'h73, 7'h0F:        fmt = sys ? 1 : 7;
      default:             fmt = 7;
    endcase
    case (fmt)
      1:       v = sext(longint'(inst[31:20]), 12);
      2:       v = sext(longint'({inst[31:25], inst[11:7]}), 12);
      3:       v = sext(longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13);
      4:       v = sext(longint'({inst[31:12], 12'b0}), 32);
      5:       v = sext(longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21);
      default: v = 0;
    endcase
    e.imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
    e.rd_wen = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) && (inst[11:7] != 5'd0);
    e.itype = 3'(fmt);
    e.illegal = (fmt == 7);
    return e;
  endfunction

  function automatic int qSize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qPop(input int w);
    if (w == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void qPush(input int w, input exp_t e);
    if (w == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic void qClear(input int w);
    if (w == 0) q0.delete();
    else q1.delete();
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic compareEntry(input int w, input exp_t o, input exp_t e);
    checkOutput($sformatf("dut%0d.pc", w), o.pc, e.pc);
    checkOutput($sformatf("dut%0d.imm", w), o.imm, e.imm);
    checkOutput($sformatf("dut%0d.opcode", w), 64'(o.opcode), 64'(e.opcode));
    checkOutput($sformatf("dut%0d.fun3", w), 64'(o.fun3), 64'(e.fun3));
    checkOutput($sformatf("dut%0d.fun7", w), 64'(o.fun7), 64'(e.fun7));
    checkOutput($sformatf("dut%0d.rs1", w), 64'(o.rs1), 64'(e.rs1));
    checkOutput($sformatf("dut%0d.rs2", w), 64'(o.rs2), 64'(e.rs2));
    checkOutput($sformatf("dut%0d.rd", w), 64'(o.rd), 64'(e.rd));
    checkOutput($sformatf("dut%0d.rd_wen", w), 64'(o.rd_wen), 64'(e.rd_wen));
    checkOutput($sformatf("dut%0d.itype", w), 64'(o.itype), 64'(e.itype));
    checkOutput($sformatf("dut%0d.illegal", w), 64'(o.illegal), 64'(e.illegal));
  endtask

  task automatic sampleAll();
    obs0.in_ready  = bus32.in_ready;
    obs0.out_valid = bus32.out_valid;
    obs0.e = '{pc: 64'(bus32.out_pc), imm: 64'(bus32.out_imm), opcode: bus32.out_opcode,
               fun3: bus32.out_fun3, fun7: bus32.out_fun7, rs1: bus32.out_rs1, rs2: bus32.out_rs2,
               rd: bus32.out_rd, rd_wen: bus32.out_rd_wen, itype: bus32.out_itype,
               illegal: bus32.out_illegal};
    obs1.in_ready  = bus64.in_ready;
    obs1.out_valid = bus64.out_valid;
    obs1.e = '{pc: bus64.out_pc, imm: bus64.out_imm, opcode: bus64.out_opcode,
               fun3: bus64.out_fun3, fun7: bus64.out_fun7, rs1: bus64.out_rs1, rs2: bus64.out_rs2,
               rd: bus64.out_rd, rd_wen: bus64.out_rd_wen, itype: bus64.out_itype,
               illegal: bus64.out_illegal};
  endtask

  // Occupancy model: out_valid iff something is held, in_ready iff fewer than two are held.
  task automatic scoreDut(input int w, input obs_t o, input bit v, input logic [63:0] pc,
                          input logic [31:0] inst, input bit ordy, input bit fl, input bit rs);
    int sz;
    if (rs) begin
      qClear(w);
      return;
    end
    sz = qSize(w);
    checkOutput($sformatf("dut%0d.out_valid", w), 64'(o.out_valid), 64'(sz > 0));
    checkOutput($sformatf("dut%0d.in_ready", w), 64'(o.in_ready), 64'(sz < 2));
    if (o.out_valid && ordy && sz > 0) compareEntry(w, o.e, qPop(w));
    if (fl) qClear(w);
    else if (v && o.in_ready) begin
      if (w == 0) qPush(w, refDecode({32'b0, pc[31:0]}, inst, 32, 1'b0, 1'b1));
      else        qPush(w, refDecode(pc, inst, 64, 1'b1, 1'b0));
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                               input bit ordy, input bit fl, input bit rs, output bit acc);
    bus32.in_valid = v;  bus32.in_pc = pc[31:0]; bus32.in_inst = inst; bus32.out_ready = ordy;
    bus64.in_valid = v;  bus64.in_pc = pc;       bus64.in_inst = inst; bus64.out_ready = ordy;
    flush = fl;
    rst   = rs;
    #3;
    sampleAll();
    acc = v && obs0.in_ready;
    scoreDut(0, obs0, v, pc, inst, ordy, fl, rs);
    scoreDut(1, obs1, v, pc, inst, ordy, fl, rs);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit acc;
    for (int c = 0; c < 20 && (q0.size() > 0 || q1.size() > 0); c++)
      applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("drain_dut0", 64'(q0.size()), 64'd0);
    checkOutput("drain_dut1", 64'(q1.size()), 64'd0);
  endtask

  initial begin
    bit          acc;
    int          idx;
    logic [31:0] stream [8];
    logic [6:0]  opc_tab [14];
    logic [31:0] inst;
    logic [63:0] pc;

    opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                7'h13, 7'h33, 7'h0F, 7'h1B, 7'h3B, 7'h73, 7'h00};

    // Reset: held entries empty and all output data zero.
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    sampleAll();
    checkOutput("reset.out_valid", 64'(obs0.out_valid), 64'd0);
    checkOutput("reset.in_ready", 64'(obs0.in_ready), 64'd1);
    checkOutput("reset.pc", obs0.e.pc, 64'd0);
    checkOutput("reset.imm", obs1.e.imm, 64'd0);
    checkOutput("reset.fields", 64'({obs0.e.opcode, obs0.e.rd, obs0.e.itype, obs0.e.illegal, obs0.e.rd_wen}), 64'd0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);

    // ADDI x1,x2,-1 visible one cycle after acceptance.
    applyStimulus(1'b1, 64'h8000_0000, 32'hFFF1_0093, 1'b0, 1'b0, 1'b0, acc);
    sampleAll();
    checkOutput("addi.valid", 64'(obs0.out_valid), 64'd1);
    checkOutput("addi.rd", 64'(obs0.e.rd), 64'd1);
    checkOutput("addi.rs1", 64'(obs0.e.rs1), 64'd2);
    checkOutput("addi.imm32", obs0.e.imm, 64'h0000_0000_FFFF_FFFF);
    checkOutput("addi.itype", 64'(obs0.e.itype), 64'd1);
    checkOutput("addi.rd_wen", 64'(obs0.e.rd_wen), 64'd1);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // JAL x0,-4 then BEQ x0,x0,+8 (replace path).
    applyStimulus(1'b1, 64'h100, 32'hFFDF_F06F, 1'b0, 1'b0, 1'b0, acc);
    sampleAll();
    checkOutput("jal.imm32", obs0.e.imm, 64'h0000_0000_FFFF_FFFC);
    checkOutput("jal.rd_wen", 64'(obs0.e.rd_wen), 64'd0);
    applyStimulus(1'b1, 64'h104, 32'h0000_0463, 1'b1, 1'b0, 1'b0, acc);
    sampleAll();
    checkOutput("beq.imm", obs1.e.imm, 64'd8);
    checkOutput("beq.itype", 64'(obs0.e.itype), 64'd3);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // LUI sign extension at XLEN=64; ADDW legal only with RV64 enabled.
    applyStimulus(1'b1, 64'h200, 32'h8000_02B7, 1'b0, 1'b0, 1'b0, acc);
    sampleAll();
    checkOutput("lui.imm64", obs1.e.imm, 64'hFFFF_FFFF_8000_0000);
    checkOutput("lui.imm32", obs0.e.imm, 64'h0000_0000_8000_0000);
    applyStimulus(1'b1, 64'h204, 32'h0031_00BB, 1'b1, 1'b0, 1'b0, acc);
    sampleAll();
    checkOutput("addw.illegal32", 64'(obs0.e.illegal), 64'd1);
    checkOutput("addw.illegal64", 64'(obs1.e.illegal), 64'd0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // Stream of 8 with out_ready low for three cycles.
    for (int i = 0; i < 8; i++) begin
      stream[i] = $urandom;
      stream[i][6:0] = opc_tab[i];
    end
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      applyStimulus(1'b1, 64'h1000 + 64'(idx * 4), stream[idx], !(c >= 1 && c <= 3), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    checkOutput("stream.accepted", 64'(idx), 64'd8);
    drain();

    // Flush in SKID and in MAIN while an entry is offered.
    applyStimulus(1'b1, 64'h300, 32'h0010_0093, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 64'h304, 32'h0020_0113, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 64'h308, 32'h0030_0193, 1'b0, 1'b1, 1'b0, acc);
    sampleAll();
    checkOutput("flush_skid.out_valid", 64'(obs0.out_valid), 64'd0);
    checkOutput("flush_skid.in_ready", 64'(obs0.in_ready), 64'd1);
    applyStimulus(1'b1, 64'h30C, 32'h0040_0213, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 64'h310, 32'h0050_0293, 1'b0, 1'b1, 1'b0, acc);
    sampleAll();
    checkOutput("flush_main.out_valid", 64'(obs1.out_valid), 64'd0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b0, acc);

    // All-zero instruction is illegal; reset while holding it.
    applyStimulus(1'b1, 64'h400, 32'h0000_0000, 1'b0, 1'b0, 1'b0, acc);
    sampleAll();
    checkOutput("zero.illegal", 64'(obs0.e.illegal), 64'd1);
    checkOutput("zero.itype", 64'(obs0.e.itype), 64'd7);
    checkOutput("zero.imm", obs0.e.imm, 64'd0);
    checkOutput("zero.rd_wen", 64'(obs0.e.rd_wen), 64'd0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
    sampleAll();
    checkOutput("rst_mid.out_valid", 64'(obs0.out_valid), 64'd0);
    checkOutput("rst_mid.pc", obs0.e.pc, 64'd0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, acc);

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      inst = $urandom;
      inst[6:0] = opc_tab[$urandom_range(0, 13)];
      pc = {32'($urandom), 32'($urandom)};
      applyStimulus($urandom_range(0, 3) != 0, pc, inst, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 24) == 0, 1'b0, acc);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
